// File: rtl/snap_capture_ctrl.sv
// Snapshot capture sequencer: writes din into a 2^ADDR_W-deep BRAM
// under software control, in one-shot or circular mode.
module snap_capture_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) (
  input  logic              OPB_Clk,
  input  logic              OPB_Rst,
  input  logic [31:0]       ctrl,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              trig,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic [31:0]       status
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   C_ONE = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic              en_q;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic [31:0]       status_d;
  logic              en_rise, en_fall;
  logic              qual, start, wr, last, circ;
  logic              unused_ctrl;

  assign en_rise = ctrl[0] & ~en_q;
  assign en_fall = ~ctrl[0] & en_q;
  assign start   = ctrl[1] ? trig : 1'b1;
  assign qual    = ctrl[2] ? din_valid : 1'b1;
  assign circ    = ctrl[3];
  assign last    = &cnt_q[ADDR_W-1:0];
  assign unused_ctrl = ^ctrl[31:4];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    wr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_rise) begin
          state_d = ARMED;
          cnt_d   = '0;
          wrap_d  = 1'b0;
        end
      end
      ARMED: begin
        if (en_fall) begin
          state_d = IDLE;
          cnt_d   = '0;
          wrap_d  = 1'b0;
        end else if (start) begin
          state_d = CAPTURE;
          wr      = qual;
        end
      end
      CAPTURE: begin
        wr = qual;
        if (en_fall) state_d = DONE;
      end
      DONE: begin
        if (en_rise) begin
          state_d = ARMED;
          cnt_d   = '0;
          wrap_d  = 1'b0;
        end
      end
    endcase
    // Circular keeps count as the next address; one-shot counts to 2^ADDR_W.
    if (wr) begin
      if (circ) begin
        cnt_d = {1'b0, cnt_q[ADDR_W-1:0] + A_ONE};
        if (last) wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + C_ONE;
        if (last) state_d = DONE;
      end
    end
  end

  always_comb begin
    status_d             = '0;
    status_d[31]         = (state_d == DONE);
    status_d[30]         = (state_d == ARMED) || (state_d == CAPTURE);
    status_d[29]         = wrap_d;
    status_d[ADDR_W:0]   = cnt_d;
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q   <= IDLE;
      en_q      <= ctrl[0];
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
      bram_addr <= '0;
      bram_data <= '0;
      bram_we   <= 1'b0;
      status    <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= ctrl[0];
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      bram_we <= wr;
      status  <= status_d;
      if (wr) begin
        bram_addr <= cnt_q[ADDR_W-1:0];
        bram_data <= din;
      end
    end
  end

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Directed/randomized bench for snap_capture_ctrl with a
// capture-window reference model.
module tb_snap_capture_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              OPB_Rst;
  logic [31:0]       ctrl;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              trig;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;
  logic [31:0]       status;

  int vectors;
  int miscompares;

  // Model: cap_on marks cycles where a qualifying word must be written;
  // nwr is the number of words written in the current capture.
  bit cap_on;
  int nwr;
  bit circ_m, wes_m, trs_m;

  snap_capture_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .OPB_Clk  (clk),
    .OPB_Rst  (OPB_Rst),
    .ctrl     (ctrl),
    .din      (din),
    .din_valid(din_valid),
    .trig     (trig),
    .bram_addr(bram_addr),
    .bram_data(bram_data),
    .bram_we  (bram_we),
    .status   (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] st(bit d, bit b, bit w, int c);
    logic [31:0] s;
    s = 32'b0;
    s[31] = d;
    s[30] = b;
    s[29] = w;
    s[ADDR_W:0] = c[ADDR_W:0];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit en, input bit tg, input bit dv);
    logic [31:0]       r;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] ea;
    bit                q, ew;
    r = $urandom;
    d = {$urandom, $urandom};
    ctrl      = {r[31:4], circ_m, wes_m, trs_m, en};
    din       = d;
    din_valid = dv;
    trig      = tg;
    q  = wes_m ? dv : 1'b1;
    ew = cap_on && q && !OPB_Rst;
    ea = ADDR_W'(nwr % DEPTH);
    @(posedge clk);
    #1;
    chk("bram_we", 64'(bram_we), 64'(ew));
    if (ew) begin
      chk("bram_addr", 64'(bram_addr), 64'(ea));
      chk("bram_data", bram_data, d);
      nwr++;
      if (!circ_m && nwr == DEPTH) cap_on = 1'b0;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cap_on = 1'b0;
    nwr = 0;
    circ_m = 1'b0;
    wes_m = 1'b0;
    trs_m = 1'b0;
    OPB_Rst = 1'b1;
    ctrl = '0;
    din = '0;
    din_valid = 1'b0;
    trig = 1'b0;

    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_status", 64'(status), 64'(0));
    chk("rst_addr", 64'(bram_addr), 64'(0));
    chk("rst_data", bram_data, 64'(0));
    OPB_Rst = 1'b0;
    cyc(0, 0, 0);

    // 1: immediate one-shot
    cyc(1, 0, 0);
    cap_on = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1, 0, 0);
    chk("t1_n", 64'(nwr), 64'(DEPTH));
    chk("t1_status", 64'(status), 64'(st(1, 0, 0, 16)));
    cyc(0, 0, 0);
    chk("t1_hold", 64'(status), 64'(st(1, 0, 0, 16)));

    // 2: triggered start, pulse 20 cycles after arming
    trs_m = 1'b1;
    nwr = 0;
    cyc(1, 0, 0);
    for (int i = 1; i < 20; i++) begin
      cyc(1, 0, 0);
      chk("t2_wait", 64'(status), 64'(st(0, 1, 0, 0)));
    end
    cap_on = 1'b1;
    cyc(1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0);
      if (nwr < DEPTH)
        chk("t2_busy", 64'(status), 64'(st(0, 1, 0, nwr)));
      else
        chk("t2_done", 64'(status), 64'(st(1, 0, 0, 16)));
    end
    cyc(0, 0, 0);
    trs_m = 1'b0;

    // 3: valid-qualified, din_valid toggling
    wes_m = 1'b1;
    nwr = 0;
    cyc(1, 0, 0);
    cap_on = 1'b1;
    for (int i = 0; i < 40; i++) cyc(1, 0, (i % 2) == 0);
    chk("t3_n", 64'(nwr), 64'(DEPTH));
    chk("t3_status", 64'(status), 64'(st(1, 0, 0, 16)));
    cyc(0, 0, 0);

    // 4: circular, random valid, 40 qualifying words
    circ_m = 1'b1;
    nwr = 0;
    cyc(1, 0, 0);
    cap_on = 1'b1;
    for (int i = 0; i < 400 && nwr < 40; i++)
      cyc(1, 0, 1'($urandom_range(0, 1)));
    chk("t4_n", 64'(nwr), 64'(40));
    cyc(0, 0, 0);
    cap_on = 1'b0;
    cyc(0, 0, 0);
    chk("t4_status", 64'(status), 64'(st(1, 0, 1, 8)));

    // 5: one-shot partial, drop cycle carries the 5th write
    circ_m = 1'b0;
    wes_m = 1'b0;
    nwr = 0;
    cyc(1, 0, 0);
    cap_on = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    cap_on = 1'b0;
    cyc(0, 0, 0);
    chk("t5_status", 64'(status), 64'(32'h8000_0005));
    nwr = 0;
    cyc(1, 0, 0);
    chk("t5_rearm", 64'(status), 64'(st(0, 1, 0, 0)));
    cap_on = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    cap_on = 1'b0;
    cyc(0, 0, 0);
    chk("t5_status2", 64'(status), 64'(st(1, 0, 0, 4)));

    // 6: reset mid-capture with enable held
    nwr = 0;
    cyc(1, 0, 0);
    cap_on = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    OPB_Rst = 1'b1;
    cap_on = 1'b0;
    cyc(1, 0, 0);
    chk("t6_addr", 64'(bram_addr), 64'(0));
    chk("t6_data", bram_data, 64'(0));
    chk("t6_status", 64'(status), 64'(0));
    OPB_Rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0);
      chk("t6_noarm", 64'(status), 64'(0));
    end
    cyc(0, 0, 0);
    nwr = 0;
    cyc(1, 0, 0);
    cap_on = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    chk("t6_busy", 64'(status), 64'(st(0, 1, 0, 3)));
    cyc(0, 0, 0);
    cap_on = 1'b0;
    cyc(0, 0, 0);
    chk("t6_done", 64'(status), 64'(st(1, 0, 0, 4)));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
